// File: rtl/tour_pkg.sv
// Shared definitions for the 5x5 knight's tour solver and the block that replays its moves.
package tour_pkg;
  localparam int BOARD_DIM = 5;
  localparam int NUM_MOVES = 24;

  typedef enum logic [2:0] {IDLE, INIT, POSSIBLE, MAKE_MOVE, BACKUP} state_t;

  // Knight displacement per one-hot move bit
  localparam logic signed [3:0] DX [8] = '{-4'sd1, 4'sd1, -4'sd2, -4'sd2, -4'sd1, 4'sd1, 4'sd2, 4'sd2};
  localparam logic signed [3:0] DY [8] = '{4'sd2, 4'sd2, 4'sd1, -4'sd1, -4'sd2, -4'sd2, -4'sd1, 4'sd1};

  // Apply (or undo, when back=1) a one-hot move to a coordinate, modulo 8.
  function automatic logic [2:0] step_x(input logic [2:0] p, input logic [7:0] mv, input logic back);
    logic [2:0] d;
    d = '0;
    for (int i = 0; i < 8; i++) if (mv[i]) d = DX[i][2:0];
    return back ? p - d : p + d;
  endfunction

  function automatic logic [2:0] step_y(input logic [2:0] p, input logic [7:0] mv, input logic back);
    logic [2:0] d;
    d = '0;
    for (int i = 0; i < 8; i++) if (mv[i]) d = DY[i][2:0];
    return back ? p - d : p + d;
  endfunction
endpackage

// File: rtl/tour_poss_moves.sv
// Mask of knight moves from (xx,yy) that land on the 5x5 board.
module tour_poss_moves
  import tour_pkg::*;
(
  input  logic [2:0] xx,
  input  logic [2:0] yy,
  output logic [7:0] poss
);
  logic signed [4:0] px, py;

  always_comb begin
    poss = '0;
    px   = '0;
    py   = '0;
    for (int i = 0; i < 8; i++) begin
      // widen to 5 bits so 7+2 and 0-2 cannot wrap into range
      px = $signed({2'b00, xx}) + $signed({DX[i][3], DX[i]});
      py = $signed({2'b00, yy}) + $signed({DY[i][3], DY[i]});
      poss[i] = (px >= 5'sd0) && (px < 5'sd5) && (py >= 5'sd0) && (py < 5'sd5);
    end
  end
endmodule

// File: rtl/tour_logic.sv
// Backtracking knight's tour solver on a 5x5 board; the found path is read back one move per indx.
module tour_logic
  import tour_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [2:0] x_start,
  input  logic [2:0] y_start,
  input  logic       go,
  input  logic [4:0] indx,
  output logic [7:0] move,
  output logic       done,
  output logic       no_tour
);
  state_t     state_q, state_d;
  logic [4:0] board_q [BOARD_DIM][BOARD_DIM];
  logic [4:0] board_d [BOARD_DIM][BOARD_DIM];
  logic [7:0] stack_q [NUM_MOVES];
  logic [7:0] stack_d [NUM_MOVES];
  logic [7:0] poss_q  [NUM_MOVES];
  logic [7:0] poss_d  [NUM_MOVES];
  logic [2:0] xx_q, xx_d, yy_q, yy_d;
  logic [4:0] move_num_q, move_num_d;
  logic [7:0] try_q, try_d;
  logic       done_q, done_d, no_tour_q, no_tour_d;

  logic [7:0] poss_w, popped;
  logic [2:0] nx, ny;
  logic       hit;

  tour_poss_moves u_poss (.xx(xx_q), .yy(yy_q), .poss(poss_w));

  always_comb begin
    state_d    = state_q;
    board_d    = board_q;
    stack_d    = stack_q;
    poss_d     = poss_q;
    xx_d       = xx_q;
    yy_d       = yy_q;
    move_num_d = move_num_q;
    try_d      = try_q;
    done_d     = 1'b0;
    no_tour_d  = 1'b0;

    nx     = step_x(xx_q, try_q, 1'b0);
    ny     = step_y(yy_q, try_q, 1'b0);
    popped = (move_num_q != 5'd0) ? stack_q[move_num_q - 5'd1] : 8'h00;
    hit    = (|(poss_q[move_num_q] & try_q)) && (nx < 3'(BOARD_DIM)) && (ny < 3'(BOARD_DIM))
             && (board_q[nx][ny] == 5'd0);

    case (state_q)
      IDLE: if (go) state_d = INIT;
      INIT: begin
        for (int i = 0; i < BOARD_DIM; i++)
          for (int j = 0; j < BOARD_DIM; j++) board_d[i][j] = 5'd0;
        if (x_start < 3'(BOARD_DIM) && y_start < 3'(BOARD_DIM)) board_d[x_start][y_start] = 5'd1;
        xx_d       = x_start;
        yy_d       = y_start;
        move_num_d = 5'd0;
        state_d    = POSSIBLE;
      end
      POSSIBLE: begin
        poss_d[move_num_q] = poss_w;
        try_d   = 8'h01;
        state_d = MAKE_MOVE;
      end
      MAKE_MOVE: begin
        if (hit) begin
          stack_d[move_num_q] = try_q;
          xx_d = nx;
          yy_d = ny;
          board_d[nx][ny] = move_num_q + 5'd2;
          if (move_num_q == 5'(NUM_MOVES - 1)) begin
            done_d  = 1'b1;
            state_d = IDLE;
          end else begin
            move_num_d = move_num_q + 5'd1;
            state_d    = POSSIBLE;
          end
        end else if (try_q != 8'h80) begin
          try_d = try_q << 1;
        end else begin
          state_d = BACKUP;
        end
      end
      BACKUP: begin
        if (move_num_q == 5'd0) begin
          no_tour_d = 1'b1;
          state_d   = IDLE;
        end else begin
          if (xx_q < 3'(BOARD_DIM) && yy_q < 3'(BOARD_DIM)) board_d[xx_q][yy_q] = 5'd0;
          move_num_d = move_num_q - 5'd1;
          xx_d       = step_x(xx_q, popped, 1'b1);
          yy_d       = step_y(yy_q, popped, 1'b1);
          try_d      = popped << 1;
          // a popped last-choice move means that level is exhausted too
          state_d    = (popped == 8'h80) ? BACKUP : MAKE_MOVE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      xx_q       <= '0;
      yy_q       <= '0;
      move_num_q <= '0;
      try_q      <= '0;
      done_q     <= 1'b0;
      no_tour_q  <= 1'b0;
      for (int i = 0; i < BOARD_DIM; i++)
        for (int j = 0; j < BOARD_DIM; j++) board_q[i][j] <= '0;
      for (int k = 0; k < NUM_MOVES; k++) begin
        stack_q[k] <= '0;
        poss_q[k]  <= '0;
      end
    end else begin
      state_q    <= state_d;
      xx_q       <= xx_d;
      yy_q       <= yy_d;
      move_num_q <= move_num_d;
      try_q      <= try_d;
      done_q     <= done_d;
      no_tour_q  <= no_tour_d;
      board_q    <= board_d;
      stack_q    <= stack_d;
      poss_q     <= poss_d;
    end
  end

  assign move    = (indx < 5'(NUM_MOVES)) ? stack_q[indx] : 8'h00;
  assign done    = done_q;
  assign no_tour = no_tour_q;
endmodule

// File: tb/tb_tour_logic.sv
// Directed/randomized bench for tour_logic against an integer depth-first tour search.
module tb_tour_logic;
  localparam int BUDGET = 200_000_000;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [2:0] x_start = '0, y_start = '0;
  logic       go = 1'b0;
  logic [4:0] indx = '0;
  logic [7:0] move;
  logic       done, no_tour;

  tour_logic dut (
    .clk(clk), .rst_n(rst_n), .x_start(x_start), .y_start(y_start),
    .go(go), .indx(indx), .move(move), .done(done), .no_tour(no_tour)
  );

  always #10 clk = ~clk;

  int checks = 0, failures = 0;
  int done_cnt = 0, nt_cnt = 0;
  int tdx [8] = '{-1, 1, -2, -2, -1, 1, 2, 2};
  int tdy [8] = '{2, 2, 1, -1, -2, -2, -1, 1};
  logic [7:0] exp_stack [24];
  logic [7:0] got [24];

  always @(negedge clk) begin
    done_cnt <= done_cnt + int'(done);
    nt_cnt   <= nt_cnt + int'(no_tour);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // First tour in move-bit order 0..7, found by plain depth-first search over squares.
  task automatic model_solve(input int sx, input int sy, output bit found);
    bit vis [5][5];
    int dir [24];
    int cx, cy, depth, d, nx, ny;
    for (int i = 0; i < 5; i++) for (int j = 0; j < 5; j++) vis[i][j] = 0;
    for (int i = 0; i < 24; i++) dir[i] = -1;
    cx = sx; cy = sy; vis[cx][cy] = 1; depth = 0; found = 0; nx = 0; ny = 0;
    forever begin
      d = dir[depth] + 1;
      while (d < 8) begin
        nx = cx + tdx[d];
        ny = cy + tdy[d];
        if (nx >= 0 && nx < 5 && ny >= 0 && ny < 5 && !vis[nx][ny]) break;
        d++;
      end
      if (d < 8) begin
        dir[depth] = d;
        cx = nx; cy = ny; vis[cx][cy] = 1;
        depth++;
        if (depth == 24) begin found = 1; break; end
        dir[depth] = -1;
      end else begin
        if (depth == 0) break;
        vis[cx][cy] = 0;
        depth--;
        cx -= tdx[dir[depth]];
        cy -= tdy[dir[depth]];
      end
    end
    for (int i = 0; i < 24; i++) exp_stack[i] = found ? 8'(1 << dir[i]) : 8'h00;
  endtask

  task automatic start(input int x, input int y);
    @(negedge clk);
    x_start = 3'(x); y_start = 3'(y); go = 1'b1;
    @(negedge clk);
    go = 1'b0;
  endtask

  task automatic wait_end(input string tag);
    bit ok;
    ok = 0;
    for (int c = 0; c < BUDGET && !ok; c++) begin
      @(negedge clk);
      if (done || no_tour) ok = 1;
    end
    chk({tag, "_finish"}, 32'(ok), 32'd1);
    repeat (3) @(negedge clk);
  endtask

  task automatic check_stack(input string tag);
    for (int k = 0; k < 24; k++) begin
      @(negedge clk);
      indx = 5'(k);
      #1;
      got[k] = move;
      chk($sformatf("%s_mv%0d", tag, k), 32'(move), 32'(exp_stack[k]));
    end
  endtask

  initial begin
    bit f;
    int d0, n0, cnt, px, py, b, k;
    bit seen [5][5];

    // reset values
    repeat (3) @(negedge clk);
    indx = 5'($urandom_range(0, 23));
    #1;
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_no_tour", 32'(no_tour), 32'd0);
    chk("rst_move", 32'(move), 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // centre start: tour exists; replay must cover 25 distinct squares
    model_solve(2, 2, f);
    d0 = done_cnt; n0 = nt_cnt;
    start(2, 2);
    wait_end("c22");
    chk("c22_done_cnt", 32'(done_cnt - d0), 32'(f));
    chk("c22_nt_cnt", 32'(nt_cnt - n0), 32'(!f));
    check_stack("c22");
    for (int i = 0; i < 5; i++) for (int j = 0; j < 5; j++) seen[i][j] = 0;
    px = 2; py = 2; seen[2][2] = 1; cnt = 1;
    for (int i = 0; i < 24; i++) begin
      b = -1;
      for (int j = 0; j < 8; j++) if (got[i][j]) b = j;
      if (b >= 0) begin
        px += tdx[b]; py += tdy[b];
        if (px >= 0 && px < 5 && py >= 0 && py < 5 && !seen[px][py]) begin
          seen[px][py] = 1; cnt++;
        end
      end
    end
    chk("c22_distinct", 32'(cnt), 32'd25);

    // corner start with a second go 10 cycles in, which must be ignored
    model_solve(0, 0, f);
    d0 = done_cnt; n0 = nt_cnt;
    start(0, 0);
    repeat (8) @(negedge clk);
    start(4, 4);
    wait_end("c00");
    repeat (20) @(negedge clk);
    chk("c00_done_cnt", 32'(done_cnt - d0), 32'd1);
    chk("c00_nt_cnt", 32'(nt_cnt - n0), 32'd0);
    check_stack("c00");
    cnt = 0;
    for (int i = 0; i < 24; i++) if ($onehot(got[i])) cnt++;
    chk("c00_onehot", 32'(cnt), 32'd24);

    // random indx sweep for 100 cycles, no go: contents must hold
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      k = $urandom_range(0, 23);
      indx = 5'(k);
      #1;
      chk($sformatf("hold_%0d_idx%0d", i, k), 32'(move), 32'(exp_stack[k]));
    end

    // odd-parity start: no tour
    model_solve(0, 1, f);
    d0 = done_cnt; n0 = nt_cnt;
    start(0, 1);
    wait_end("c01");
    chk("c01_nt_cnt", 32'(nt_cnt - n0), 32'(!f));
    chk("c01_done_cnt", 32'(done_cnt - d0), 32'(f));

    // reset in the middle of a solve
    model_solve(2, 2, f);
    d0 = done_cnt; n0 = nt_cnt;
    start(2, 2);
    repeat (40 + $urandom_range(0, 40)) @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      indx = 5'($urandom_range(0, 23));
      #1;
      chk($sformatf("midrst_move%0d", i), 32'(move), 32'd0);
    end
    chk("midrst_done", 32'(done), 32'd0);
    chk("midrst_no_tour", 32'(no_tour), 32'd0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    chk("midrst_no_pulse", 32'((done_cnt - d0) + (nt_cnt - n0)), 32'd0);
    start(2, 2);
    wait_end("rerun");
    chk("rerun_done_cnt", 32'(done_cnt - d0), 32'(f));
    check_stack("rerun");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/tour_logic.md
TOUR_LOGIC -- requirements
Module: tour_logic

Interface
REQ-001 SHALL have port clk, input, 1 bit: 50 MHz system clock; single clock domain.
REQ-002 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-003 SHALL have port x_start, input, 3 bits: starting column, legal range 0..4.
REQ-004 SHALL have port y_start, input, 3 bits: starting row, legal range 0..4.
REQ-005 SHALL have port go, input, 1 bit: one-cycle pulse that starts the solver, sampled only in IDLE.
REQ-006 SHALL have port indx, input, 5 bits: read address of a stored move, range 0..23.
REQ-007 SHALL have port move, output, 8 bits: one-hot move stored at indx.
REQ-008 SHALL have port done, output, 1 bit: one-cycle pulse when a full tour is found.
REQ-009 SHALL have port no_tour, output, 1 bit: one-cycle pulse when the search space is exhausted.

Function
REQ-010 SHALL solve a knight's tour on a 5x5 board: 25 squares visited exactly once, 24 moves.
REQ-011 SHALL use this move encoding as (dx,dy): bit0 (-1,+2), bit1 (+1,+2), bit2 (-2,+1), bit3 (-2,-1), bit4 (-1,-2), bit5 (+1,-2), bit6 (+2,-1), bit7 (+2,+1).
REQ-012 SHALL hold a 5x5 board array, 5 bits per square; 0 means unvisited, otherwise the square's visit order.
REQ-013 SHALL hold a 24-entry by 8-bit one-hot move stack, plus a 24-entry by 8-bit possible-moves stack.
REQ-014 SHALL hold the current position xx,yy (3 bits each), move_num (5 bits) and try (8 bits, one-hot).
REQ-015 SHALL implement the states IDLE, INIT, POSSIBLE, MAKE_MOVE and BACKUP.
REQ-016 IDLE: on go, SHALL move to INIT; go received in any other state SHALL be ignored.
REQ-017 INIT, one cycle: SHALL clear all 25 squares, then set board[x_start][y_start]=1, load xx/yy from x_start/y_start, set move_num=0, and move to POSSIBLE.
REQ-018 POSSIBLE, one cycle: SHALL store into poss[move_num] the mask of moves from (xx,yy) that stay on the board; SHALL set try=8'h01; SHALL move to MAKE_MOVE.
REQ-019 MAKE_MOVE: if (poss[move_num] & try) is nonzero and the target square is unvisited, SHALL store try into stack[move_num], update xx/yy, and write board[target]=move_num+2.
REQ-020 After a move in MAKE_MOVE: if move_num==23, SHALL pulse done and return to IDLE; otherwise SHALL increment move_num and go to POSSIBLE.
REQ-021 MAKE_MOVE, when no move is made: if try!=8'h80, SHALL shift try left by 1 and stay; if try==8'h80, SHALL go to BACKUP.
REQ-022 BACKUP: SHALL clear board[xx][yy]; SHALL decrement move_num; SHALL undo stack[move_num-1] on xx/yy; SHALL set try to that stack entry shifted left by 1.
REQ-023 After BACKUP: if the popped entry was 8'h80, SHALL stay in BACKUP; otherwise SHALL go to MAKE_MOVE.
REQ-024 If BACKUP is required while move_num==0, SHALL pulse no_tour and return to IDLE.
REQ-025 SHALL compute poss masks and position updates in 3-bit signed-safe arithmetic; out-of-range coordinates SHALL never be written to the board.
REQ-026 SHALL drive move combinationally as stack[indx]; stack contents SHALL remain stable from done until the next go.
REQ-027 SHALL make done and no_tour mutually exclusive, each exactly one clock wide.

Reset
REQ-028 While rst_n is low, SHALL force state=IDLE, done=0, no_tour=0, move_num=0, xx=yy=0, and try=0.
REQ-029 SHALL clear board and stack on reset; reset mid-search SHALL abort with no done/no_tour pulse, and the next go SHALL start clean.

Structure
REQ-030 SHALL place the following in shared package tour_pkg: BOARD_DIM=5, NUM_MOVES=24, the state enum, and the per-bit DX/DY constant tables (shared with the move-consumer block).
REQ-031 SHALL use one combinational sub-module, tour_poss_moves, that computes the on-board move mask from (xx,yy).

Verification
REQ-032 go with (x,y)=(2,2) -> done pulses once, no_tour stays 0; replaying indx 0..23 from (2,2) visits 25 distinct in-range squares.
REQ-033 go with (0,0) -> done pulses once; every stack entry is one-hot and the replayed path ends on a square with board value 25.
REQ-034 go with (0,1) (x+y odd, no tour exists) -> no_tour pulses once; done never asserts.
REQ-035 Pulse go again 10 cycles after the first go during a solve -> ignored; exactly one done results, for the first start.
REQ-036 Drop rst_n for 2 cycles mid-solve -> no pulse, all outputs at reset values; a subsequent go with (2,2) completes normally.
REQ-037 After done, sweep indx 0..23 for 100 cycles with no go -> move values unchanged.
